// File: rtl/vedic_seq_mul16_ctrl.sv
// Sequenced 16x16 unsigned multiplier built from one shared 8x8 vedic
// multiplier. Up to four byte-by-byte partial products are issued on
// successive cycles and accumulated, shifted, into a 32-bit result.
// Steps whose a-byte or b-byte is zero can be skipped, which makes the
// latency depend on the operands.

// 8x8 unsigned vedic (Urdhva-Tiryagbhyam) multiplier.
// Four 4x4 nibble products are combined: the vertical products form the
// outer terms and the crosswise sum is added in at nibble offset 4.
module vedic_8x8 (
  input  logic [7:0]  io_a,
  input  logic [7:0]  io_b,
  output logic [15:0] io_c
);

  logic [7:0] pp_ll;
  logic [7:0] pp_hl;
  logic [7:0] pp_lh;
  logic [7:0] pp_hh;
  logic [8:0] cross_sum;

  // Nibble products, then vertical terms plus the crosswise sum.
  always_comb begin
    pp_ll     = {4'b0, io_a[3:0]} * {4'b0, io_b[3:0]};
    pp_hl     = {4'b0, io_a[7:4]} * {4'b0, io_b[3:0]};
    pp_lh     = {4'b0, io_a[3:0]} * {4'b0, io_b[7:4]};
    pp_hh     = {4'b0, io_a[7:4]} * {4'b0, io_b[7:4]};
    cross_sum = {1'b0, pp_hl} + {1'b0, pp_lh};
    io_c      = {pp_hh, pp_ll} + {3'b0, cross_sum, 4'b0};
  end

endmodule

module vedic_seq_mul16_ctrl #(
  parameter bit SKIP_ZERO = 1'b1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        io_in_valid,
  output logic        io_in_ready,
  input  logic [15:0] io_in_a,
  input  logic [15:0] io_in_b,
  output logic        io_out_valid,
  input  logic        io_out_ready,
  output logic [31:0] io_out_c,
  output logic        io_busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state_q;
  logic [15:0] a_q;
  logic [15:0] b_q;
  logic [31:0] acc_q;
  logic [1:0]  step_q;
  logic [3:0]  mask_q;

  logic [7:0]  mul_a;
  logic [7:0]  mul_b;
  logic [15:0] pp;
  logic [31:0] pp_shift;
  logic [31:0] acc_d;
  logic [3:0]  mask_rem;
  logic [3:0]  req_mask;
  logic        accept;

  // Index of the lowest set bit; callers guarantee m != 0.
  function automatic logic [1:0] lowest_bit(input logic [3:0] m);
    logic [1:0] idx;
    idx = 2'd3;
    if (m[2]) idx = 2'd2;
    if (m[1]) idx = 2'd1;
    if (m[0]) idx = 2'd0;
    return idx;
  endfunction

  // Step bit0 picks the a-byte, bit1 the b-byte:
  // 0=aL*bL, 1=aH*bL, 2=aL*bH, 3=aH*bH.
  assign mul_a = step_q[0] ? a_q[15:8] : a_q[7:0];
  assign mul_b = step_q[1] ? b_q[15:8] : b_q[7:0];

  vedic_8x8 u_mul (
    .io_a (mul_a),
    .io_b (mul_b),
    .io_c (pp)
  );

  // Align the partial product to its byte weight and form the next state.
  always_comb begin
    pp_shift = {16'b0, pp};
    unique case (step_q)
      2'd0:    pp_shift = {16'b0, pp};
      2'd1,
      2'd2:    pp_shift = {8'b0, pp, 8'b0};
      default: pp_shift = {pp, 16'b0};
    endcase
    acc_d    = acc_q + pp_shift;
    mask_rem = mask_q & ~(4'b0001 << step_q);
    req_mask[0] = (io_in_a[7:0]  != 8'd0) && (io_in_b[7:0]  != 8'd0);
    req_mask[1] = (io_in_a[15:8] != 8'd0) && (io_in_b[7:0]  != 8'd0);
    req_mask[2] = (io_in_a[7:0]  != 8'd0) && (io_in_b[15:8] != 8'd0);
    req_mask[3] = (io_in_a[15:8] != 8'd0) && (io_in_b[15:8] != 8'd0);
    if (!SKIP_ZERO) req_mask = 4'b1111;
  end

  assign accept       = io_in_valid && (state_q == S_IDLE);
  assign io_in_ready  = (state_q == S_IDLE);
  assign io_out_valid = (state_q == S_DONE);
  assign io_busy      = (state_q != S_IDLE);
  assign io_out_c     = acc_q;

  // Control FSM: capture, step through the mask, hold result until taken.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      a_q     <= 16'd0;
      b_q     <= 16'd0;
      acc_q   <= 32'd0;
      step_q  <= 2'd0;
      mask_q  <= 4'd0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (accept) begin
            a_q    <= io_in_a;
            b_q    <= io_in_b;
            acc_q  <= 32'd0;
            mask_q <= req_mask;
            if (req_mask == 4'd0) begin
              step_q  <= 2'd0;
              state_q <= S_DONE;
            end else begin
              step_q  <= lowest_bit(req_mask);
              state_q <= S_CALC;
            end
          end
        end
        S_CALC: begin
          acc_q  <= acc_d;
          mask_q <= mask_rem;
          if (mask_rem == 4'd0) begin
            state_q <= S_DONE;
          end else begin
            step_q <= lowest_bit(mask_rem);
          end
        end
        S_DONE: begin
          if (io_out_ready) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vedic_seq_mul16_ctrl.sv
// Directed bench for vedic_seq_mul16_ctrl: one instance with zero-skipping
// (index 1) and one without (index 0), sharing clock and reset.
module tb_vedic_seq_mul16_ctrl;

  logic        clock;
  logic        reset_n;
  logic        in_valid  [2];
  logic        in_ready  [2];
  logic [15:0] in_a      [2];
  logic [15:0] in_b      [2];
  logic        out_valid [2];
  logic        out_ready [2];
  logic [31:0] out_c     [2];
  logic        busy      [2];

  int n_cmp = 0;
  int n_err = 0;

  vedic_seq_mul16_ctrl #(.SKIP_ZERO(1'b0)) dut0 (
    .clock        (clock),
    .reset_n      (reset_n),
    .io_in_valid  (in_valid[0]),
    .io_in_ready  (in_ready[0]),
    .io_in_a      (in_a[0]),
    .io_in_b      (in_b[0]),
    .io_out_valid (out_valid[0]),
    .io_out_ready (out_ready[0]),
    .io_out_c     (out_c[0]),
    .io_busy      (busy[0])
  );

  vedic_seq_mul16_ctrl #(.SKIP_ZERO(1'b1)) dut1 (
    .clock        (clock),
    .reset_n      (reset_n),
    .io_in_valid  (in_valid[1]),
    .io_in_ready  (in_ready[1]),
    .io_in_a      (in_a[1]),
    .io_in_b      (in_b[1]),
    .io_out_valid (out_valid[1]),
    .io_out_ready (out_ready[1]),
    .io_out_c     (out_c[1]),
    .io_busy      (busy[1])
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Issue one request to instance d and check latency, result and return to idle.
  task automatic run_op(input int d, input logic [15:0] a, input logic [15:0] b,
                        input logic [31:0] exp_c, input int exp_lat, input string tag);
    int lat;
    @(negedge clock);
    chk({tag, "_rdy"}, {31'b0, in_ready[d]}, 32'd1);
    in_a[d]      = a;
    in_b[d]      = b;
    in_valid[d]  = 1'b1;
    out_ready[d] = 1'b1;
    @(posedge clock);
    #1;
    in_valid[d] = 1'b0;
    in_a[d]     = 16'hDEAD;
    in_b[d]     = 16'hBEEF;
    lat = 1;
    while (!out_valid[d] && lat < 20) begin
      @(posedge clock);
      #1;
      lat++;
    end
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_c"}, out_c[d], exp_c);
    @(posedge clock);
    #1;
    chk({tag, "_idle"}, {30'b0, out_valid[d], in_ready[d]}, 32'd1);
  endtask

  initial begin
    reset_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid[i]  = 1'b0;
      in_a[i]      = 16'd0;
      in_b[i]      = 16'd0;
      out_ready[i] = 1'b0;
    end
    repeat (2) @(posedge clock);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("rst_valid", {31'b0, out_valid[i]}, 32'd0);
      chk("rst_c",     out_c[i], 32'd0);
      chk("rst_busy",  {31'b0, busy[i]}, 32'd0);
      chk("rst_ready", {31'b0, in_ready[i]}, 32'd1);
    end
    @(negedge clock);
    reset_n = 1'b1;

    // Zero-skipping instance
    run_op(1, 16'h1234, 16'h5678, 32'h06260060, 5, "s1_1234");
    run_op(1, 16'hFFFF, 16'hFFFF, 32'hFFFE0001, 5, "s1_ffff");
    run_op(1, 16'h00AB, 16'h00CD, 32'h000088EF, 2, "s1_abcd");
    run_op(1, 16'h0000, 16'h1234, 32'h00000000, 1, "s1_zero");
    run_op(1, 16'h0100, 16'h0100, 32'h00010000, 2, "s1_hh");
    run_op(1, 16'h8001, 16'h0002, 32'h00010002, 3, "s1_mix");

    // Always-four-steps instance
    run_op(0, 16'hFFFF, 16'hFFFF, 32'hFFFE0001, 5, "s0_ffff");
    run_op(0, 16'h00AB, 16'h00CD, 32'h000088EF, 5, "s0_abcd");
    run_op(0, 16'h0000, 16'h1234, 32'h00000000, 5, "s0_zero");

    // Backpressure in DONE with a new request pending
    @(negedge clock);
    in_a[1] = 16'h00AB; in_b[1] = 16'h00CD;
    in_valid[1] = 1'b1; out_ready[1] = 1'b0;
    @(posedge clock); #1;
    in_a[1] = 16'h0003; in_b[1] = 16'h0005;
    @(posedge clock); #1;
    chk("bp_enter", {31'b0, out_valid[1]}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clock); #1;
      chk("bp_valid", {31'b0, out_valid[1]}, 32'd1);
      chk("bp_c",     out_c[1], 32'h000088EF);
      chk("bp_ready", {31'b0, in_ready[1]}, 32'd0);
    end
    @(negedge clock);
    out_ready[1] = 1'b1;
    @(posedge clock); #1;
    chk("bp_rel_valid", {31'b0, out_valid[1]}, 32'd0);
    chk("bp_rel_ready", {31'b0, in_ready[1]}, 32'd1);
    @(posedge clock); #1;
    chk("bp_take_busy", {31'b0, busy[1]}, 32'd1);
    in_valid[1] = 1'b0;
    @(posedge clock); #1;
    chk("bp_new_valid", {31'b0, out_valid[1]}, 32'd1);
    chk("bp_new_c",     out_c[1], 32'h0000000F);
    @(posedge clock); #1;
    chk("bp_new_idle", {31'b0, in_ready[1]}, 32'd1);

    // Reset in the second CALC cycle abandons the operation
    @(negedge clock);
    in_a[1] = 16'h1234; in_b[1] = 16'h5678; in_valid[1] = 1'b1;
    @(posedge clock); #1;
    in_valid[1] = 1'b0;
    @(posedge clock); #1;
    chk("ar_calc_busy", {31'b0, busy[1]}, 32'd1);
    reset_n = 1'b0;
    #1;
    chk("ar_valid", {31'b0, out_valid[1]}, 32'd0);
    chk("ar_c",     out_c[1], 32'd0);
    chk("ar_busy",  {31'b0, busy[1]}, 32'd0);
    chk("ar_ready", {31'b0, in_ready[1]}, 32'd1);
    @(negedge clock);
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clock); #1;
      chk("ar_no_out", {31'b0, out_valid[1]}, 32'd0);
    end
    run_op(1, 16'h0003, 16'h0005, 32'h0000000F, 2, "ar_after");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
